regfile_shift_unit: RTL and testbench

REGFILE_SHIFT_UNIT -- requirements
Module: regfile_shift_unit

---
 rtl/regfile_shift_unit.sv | 53 +++++
 tb/tb_regfile_shift_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_shift_unit.sv
// 32 x 64-bit register bank with two asynchronous read ports and one write port,
// plus a combinational shifter fed by read port 1.
module regfile_shift_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic [4:0]  WriteReg,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    input  logic [31:0] Inst,
    input  logic [1:0]  Shift,
    output logic [5:0]  ShiftN,
    output logic [63:0] ShiftOut
);

    logic [63:0] regs_q [32];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 64'h0;
            end
        end else if (RegWrite && (WriteReg != 5'd0)) begin
            regs_q[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        ReadData1 = 64'h0;
        ReadData2 = 64'h0;
        if (Reset) begin
            ReadData1 = (ReadReg1 == 5'd0) ? 64'h0 : regs_q[ReadReg1];
            ReadData2 = (ReadReg2 == 5'd0) ? 64'h0 : regs_q[ReadReg2];
        end
    end

    assign ShiftN = Inst[25:20];

    always_comb begin
        ShiftOut = ReadData1;
        case (Shift)
            2'b00:   ShiftOut = ReadData1 << ShiftN;
            2'b01:   ShiftOut = ReadData1 >> ShiftN;
            2'b10:   ShiftOut = $unsigned($signed(ReadData1) >>> ShiftN);
            default: ShiftOut = ReadData1;
        endcase
    end

endmodule

// File: tb/tb_regfile_shift_unit.sv
// Scoreboard bench for regfile_shift_unit: stimulus pushes expected read/shift results,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_shift_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [4:0]  WriteReg = '0;
    logic [63:0] WriteData = '0;
    logic [31:0] Inst = '0;
    logic [1:0]  Shift = '0;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [5:0]  ShiftN;
    logic [63:0] ShiftOut;

    regfile_shift_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .Inst      (Inst),
        .Shift     (Shift),
        .ShiftN    (ShiftN),
        .ShiftOut  (ShiftOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [5:0]  sn;
        logic [63:0] so;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] model [32];
    int          total = 0;
    int          bad = 0;

    // Bit-by-bit shift reference: each result bit picks its source bit or the fill.
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input int n,
                                              input logic [1:0] op);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            if (op == 2'd0)      r[i] = (i >= n) ? a[i - n] : 1'b0;
            else if (op == 2'd1) r[i] = (i + n <= 63) ? a[i + n] : 1'b0;
            else if (op == 2'd2) r[i] = (i + n <= 63) ? a[i + n] : a[63];
            else                 r[i] = a[i];
        end
        return r;
    endfunction

    task automatic check64(input string tag, input string field, input logic [63:0] act,
                           input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check64(mon_e.tag, "ReadData1", ReadData1, mon_e.rd1);
            check64(mon_e.tag, "ReadData2", ReadData2, mon_e.rd2);
            check64(mon_e.tag, "ShiftN", {58'h0, ShiftN}, {58'h0, mon_e.sn});
            check64(mon_e.tag, "ShiftOut", ShiftOut, mon_e.so);
        end
    end

    // One cycle: commit last cycle's write to the model at the edge, then drive new
    // inputs and queue what the DUT must show before the next edge.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [5:0] n, input logic [1:0] sh, input string tag,
                         input bit force_so = 1'b0, input logic [63:0] so_req = '0);
        exp_t        e;
        logic [31:0] inst;
        @(posedge Clk);
        if (Reset && RegWrite && (WriteReg != 5'd0)) model[WriteReg] = WriteData;
        #1;
        inst        = $urandom;
        inst[25:20] = n;
        Reset       = rst;
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        Inst      = inst;
        Shift     = sh;
        e.tag = tag;
        e.rd1 = model[r1];
        e.rd2 = model[r2];
        e.sn  = n;
        e.so  = force_so ? so_req : ref_shift(model[r1], int'(n), sh);
        sb.push_back(e);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] v;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;

        // Held in reset: writes blocked, every read is zero.
        cycle(1'b0, 1'b1, 5'd3, rand64(), 5'd3, 5'd31, 6'd0, 2'd3, "reset_hold");
        cycle(1'b0, 1'b1, 5'd3, rand64(), 5'd3, 5'd17, 6'd5, 2'd0, "reset_hold");

        // Write x5: old value before the edge, new value after.
        cycle(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd5, 6'd0, 2'd3, "wr_before",
              1'b1, 64'h0);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 6'd0, 2'd3, "wr_after",
              1'b1, 64'hDEAD_BEEF_0123_4567);

        // x0 guard.
        cycle(1'b1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 6'd0, 2'd3, "x0_wr");
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 6'd7, 2'd1, "x0_rd", 1'b1, 64'h0);

        // RegWrite=0 must leave x7 alone.
        v = rand64();
        cycle(1'b1, 1'b1, 5'd7, v, 5'd7, 5'd5, 6'd0, 2'd3, "x7_wr");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 5'd7, rand64(), 5'd7, 5'd7, 6'd0, 2'd3, "nowrite", 1'b1, v);
        end

        // Directed shifts by 4.
        cycle(1'b1, 1'b1, 5'd1, 64'h8000_0000_0000_00F0, 5'd0, 5'd0, 6'd0, 2'd0, "x1_wr");
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, 6'd4, 2'd0, "sll4", 1'b1,
              64'h0000_0000_0000_0F00);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, 6'd4, 2'd1, "srl4", 1'b1,
              64'h0800_0000_0000_000F);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, 6'd4, 2'd2, "sra4", 1'b1,
              64'hF800_0000_0000_000F);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, 6'd4, 2'd3, "pass4", 1'b1,
              64'h8000_0000_0000_00F0);

        // Boundary shift amounts.
        cycle(1'b1, 1'b1, 5'd1, 64'h8000_0000_0000_0000, 5'd0, 5'd0, 6'd0, 2'd0, "x1_wr2");
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd1, 6'd63, 2'd1, "srl63", 1'b1, 64'h1);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd1, 6'd63, 2'd2, "sra63", 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd1, 6'd63, 2'd0, "sll63", 1'b1, 64'h0);
        for (int s = 0; s < 4; s++) begin
            cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd1, 5'd0, 6'd0, 2'(s), "sh0", 1'b1,
                  64'h8000_0000_0000_0000);
        end

        // Fill some registers, then reset mid-cycle and sweep all indices.
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 1'b1, 5'(i), rand64(), 5'(i), 5'd0, 6'd0, 2'd3, "fill");
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b1, 5'd9, rand64(), 5'(i), 5'(31 - i), 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), "reset_read", 1'b1, 64'h0);
        end

        // First write after release lands on the next edge.
        v = rand64();
        cycle(1'b1, 1'b1, 5'd4, v, 5'd4, 5'd9, 6'd0, 2'd3, "post_rst_before", 1'b1, 64'h0);
        cycle(1'b1, 1'b0, 5'd4, 64'h0, 5'd4, 5'd9, 6'd0, 2'd3, "post_rst_after", 1'b1, v);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom), rand64(),
                  5'($urandom), 5'($urandom), 6'($urandom), 2'($urandom), "random");
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge Clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
